// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue
// Write-back queue in front of the 32 x 32-bit register array.
// - Accepts (addr, data) write requests over a valid/ready handshake.
// - Buffers them in a DEPTH-entry FIFO and drains at most one entry per cycle.
// - Each drained entry is presented as a registered one-hot enable plus a data word.
// - Writes to register 0 are accepted but dropped, so r0 stays zero.
// Optional feature: define REGFILE_WB_BYPASS_EN to build the read-bypass
// search over pending writes. Without it, byp_hit/byp_data are tied to zero.

module regfile_wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [AW-1:0]              in_addr,
  input  logic [DW-1:0]              in_data,
  input  logic                       drain_en,
  output logic [(1<<AW)-1:0]         we_onehot,
  output logic [DW-1:0]              wr_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  input  logic [AW-1:0]              rd_addr,
  output logic                       byp_hit,
  output logic [DW-1:0]              byp_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int NR = 1 << AW;

  logic [AW-1:0] mem_addr [DEPTH];
  logic [DW-1:0] mem_data [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic          push;
  logic          pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign in_ready = !full;

  // Address-0 requests complete the handshake but never reach storage.
  assign push = in_valid && in_ready && (in_addr != '0);
  assign pop  = drain_en && !empty;

  // Entry storage; contents are only meaningful while counted as valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[tail] <= in_addr;
      mem_data[tail] <= in_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (clr) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Output stage: enable pulses for one cycle per pop, data holds between pops.
  always_ff @(posedge clk) begin
    if (clr) begin
      we_onehot <= '0;
      wr_data   <= '0;
    end else if (pop) begin
      we_onehot <= NR'(1) << mem_addr[head];
      wr_data   <= mem_data[head];
    end else begin
      we_onehot <= '0;
    end
  end

`ifdef REGFILE_WB_BYPASS_EN
  logic [AW-1:0] out_addr;
  logic [PW-1:0] idx;

  // Address of the word currently on the output stage, for bypass matching.
  always_ff @(posedge clk) begin
    if (clr) begin
      out_addr <= '0;
    end else if (pop) begin
      out_addr <= mem_addr[head];
    end
  end

  // Search oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = '0;
    idx      = head;
    if ((|we_onehot) && (out_addr == rd_addr)) begin
      byp_hit  = 1'b1;
      byp_data = wr_data;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if ((CW'(i) < count) && (mem_addr[idx] == rd_addr)) begin
        byp_hit  = 1'b1;
        byp_data = mem_data[idx];
      end
    end
    if (rd_addr == '0) begin
      byp_hit  = 1'b0;
      byp_data = '0;
    end
  end
`else
  logic unused_rd_addr;

  assign unused_rd_addr = ^rd_addr;
  assign byp_hit        = 1'b0;
  assign byp_data       = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed testbench for regfile_wb_queue with hand-computed expectations.
// Honours REGFILE_WB_BYPASS_EN for the bypass expectations.

module tb_regfile_wb_queue;

  logic        clk;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_addr;
  logic [31:0] in_data;
  logic        drain_en;
  logic [31:0] we_onehot;
  logic [31:0] wr_data;
  logic [2:0]  count;
  logic        empty;
  logic        full;
  logic [4:0]  rd_addr;
  logic        byp_hit;
  logic [31:0] byp_data;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_wb_queue #(.DEPTH(4), .AW(5), .DW(32)) dut (
    .clk       (clk),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .drain_en  (drain_en),
    .we_onehot (we_onehot),
    .wr_data   (wr_data),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .rd_addr   (rd_addr),
    .byp_hit   (byp_hit),
    .byp_data  (byp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [4:0] a, input logic [31:0] d);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  logic [4:0]  exp_addr [14];
  logic [31:0] exp_bit;

  initial begin
    clr      = 1'b1;
    in_valid = 1'b0;
    in_addr  = '0;
    in_data  = '0;
    drain_en = 1'b0;
    rd_addr  = '0;
    tick();
    tick();
    clr = 1'b0;

    // reset state
    chk("rst_in_ready", in_ready, 1);
    chk("rst_we", we_onehot, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_byp_hit", byp_hit, 0);
    chk("rst_byp_data", byp_data, 0);

    // single push, two-edge latency, one-cycle enable
    drain_en = 1'b1;
    push_one(5'd3, 32'hDEADBEEF);
    chk("single_count_after_push", count, 1);
    chk("single_we_not_yet", we_onehot, 0);
    tick();
    chk("single_we", we_onehot, 32'h0000_0008);
    chk("single_wr_data", wr_data, 32'hDEADBEEF);
    chk("single_count_drained", count, 0);
    tick();
    chk("single_we_pulse_end", we_onehot, 0);
    chk("single_wr_data_hold", wr_data, 32'hDEADBEEF);

    // fill, refuse, drain in order
    drain_en = 1'b0;
    for (int k = 1; k <= 4; k++) push_one(5'(k), 32'h11 * k);
    chk("fill_full", full, 1);
    chk("fill_in_ready", in_ready, 0);
    chk("fill_count", count, 4);
    push_one(5'd5, 32'h55);
    chk("refused_count", count, 4);
    drain_en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      exp_bit = 32'h1 << k;
      chk($sformatf("drain_we_%0d", k), we_onehot, exp_bit);
      chk($sformatf("drain_data_%0d", k), wr_data, 32'h11 * k);
    end
    tick();
    chk("drain_we_done", we_onehot, 0);
    chk("drain_empty", empty, 1);

    // writes to r0 are swallowed
    push_one(5'd0, 32'hFFFFFFFF);
    chk("r0_count", count, 0);
    chk("r0_we_0", we_onehot, 0);
    tick();
    chk("r0_we_1", we_onehot, 0);
    chk("r0_empty", empty, 1);

    // simultaneous push/pop with wraparound over three full-depth laps
    for (int j = 0; j < 14; j++) exp_addr[j] = 5'(6 + j);
    drain_en = 1'b0;
    push_one(exp_addr[0], 32'h100 * 6);
    push_one(exp_addr[1], 32'h100 * 7);
    chk("pp_count_pre", count, 2);
    drain_en = 1'b1;
    for (int j = 0; j < 12; j++) begin
      in_valid = 1'b1;
      in_addr  = exp_addr[j + 2];
      in_data  = 32'h100 * (j + 8);
      tick();
      exp_bit = 32'h1 << exp_addr[j];
      chk($sformatf("pp_we_%0d", j), we_onehot, exp_bit);
      chk($sformatf("pp_data_%0d", j), wr_data, 32'h100 * (j + 6));
      chk($sformatf("pp_count_%0d", j), count, 2);
    end
    in_valid = 1'b0;
    for (int j = 12; j < 14; j++) begin
      tick();
      exp_bit = 32'h1 << exp_addr[j];
      chk($sformatf("pp_tail_we_%0d", j), we_onehot, exp_bit);
    end
    tick();
    chk("pp_empty", empty, 1);

    // clr discards pending entries and beats a concurrent push
    drain_en = 1'b0;
    push_one(5'd9, 32'h9);
    push_one(5'd10, 32'hA);
    push_one(5'd11, 32'hB);
    chk("clr_pre_count", count, 3);
    clr      = 1'b1;
    in_valid = 1'b1;
    in_addr  = 5'd12;
    in_data  = 32'hC;
    tick();
    clr      = 1'b0;
    in_valid = 1'b0;
    chk("clr_count", count, 0);
    chk("clr_we", we_onehot, 0);
    chk("clr_empty", empty, 1);
    chk("clr_wr_data", wr_data, 0);
    drain_en = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk($sformatf("clr_no_stale_%0d", j), we_onehot, 0);
    end

    // bypass lookup over FIFO and output stage
    drain_en = 1'b0;
    push_one(5'd5, 32'hA);
    push_one(5'd5, 32'hB);
    rd_addr = 5'd5;
    #1;
`ifdef REGFILE_WB_BYPASS_EN
    chk("byp_hit_5", byp_hit, 1);
    chk("byp_data_5", byp_data, 32'hB);
`else
    chk("byp_hit_5", byp_hit, 0);
    chk("byp_data_5", byp_data, 0);
`endif
    rd_addr = 5'd0;
    #1;
    chk("byp_hit_0", byp_hit, 0);
    rd_addr = 5'd6;
    #1;
    chk("byp_hit_miss", byp_hit, 0);
    rd_addr  = 5'd5;
    drain_en = 1'b1;
    tick();
`ifdef REGFILE_WB_BYPASS_EN
    chk("byp_out_and_fifo_data", byp_data, 32'hB);
`else
    chk("byp_out_and_fifo_data", byp_data, 0);
`endif
    tick();
`ifdef REGFILE_WB_BYPASS_EN
    chk("byp_out_only_hit", byp_hit, 1);
    chk("byp_out_only_data", byp_data, 32'hB);
`else
    chk("byp_out_only_hit", byp_hit, 0);
`endif
    tick();
    chk("byp_none_hit", byp_hit, 0);
    chk("byp_final_empty", empty, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_queue.md
# regfile_wb_queue

Write-back queue that sits directly upstream of the 32 × 32-bit register array. It accepts (address, data) write requests from the pipeline's write-back stage through a valid/ready handshake, buffers them in a small FIFO, and drains at most one entry per cycle. Each drained entry becomes a one-hot enable vector plus a data word, which drive the `en` and `d` inputs of the per-register flops. Writes to register 0 are swallowed so that r0 stays hard-wired to zero.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.
- `AW`, 5: register address width; number of registers is 2^AW.
- `DW`, 32: data width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `clr`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  write request present.
- `in_ready`  out  1  queue can accept; equals `!full`.
- `in_addr`  in  AW  destination register.
- `in_data`  in  DW  write data.
- `drain_en`  in  1  downstream permits a pop this cycle; 0 freezes draining.
- `we_onehot`  out  2^AW  registered one-hot write enable to the register flops.
- `wr_data`  out  DW  registered write data to the register flops.
- `count`  out  $clog2(DEPTH+1)  entries currently held.
- `empty`  out  1  `count == 0`.
- `full`  out  1  `count == DEPTH`.
- `rd_addr`  in  AW  read-port address for bypass lookup.
- `byp_hit`  out  1  a pending write targets `rd_addr`.
- `byp_data`  out  DW  data of the youngest pending write to `rd_addr`.

## Operation
- Push: `in_valid && in_ready` at an edge accepts the request.
  - If `in_addr == 0`, the request is accepted but not stored: `count` is unchanged and no enable is ever produced for it.
  - Otherwise the request is written at the tail and the tail pointer advances, wrapping modulo `DEPTH`.
- Pop: when `drain_en && !empty` at an edge:
  - The head entry is removed.
  - `we_onehot` is set to 1 << head.addr and `wr_data` to head.data.
- When no pop occurs at an edge, `we_onehot` is set to 0 and `wr_data` holds its previous value.
- `we_onehot` is therefore high for exactly one cycle per drained entry.
- Simultaneous push and pop: both take effect and `count` is unchanged.
- A push is refused when `full`, even if a pop occurs in the same cycle (`in_ready` is derived from the current `count` only).
- Draining is in-order (FIFO). Multiple pending writes to the same address all drain, oldest first.
- `clr` high at an edge:
  - Pointers and `count` go to 0 and `we_onehot` and `wr_data` go to 0.
  - All pending entries are discarded.
  - `clr` wins over any push or pop in the same cycle.
- Reset values: `in_ready`=1, `we_onehot`=0, `wr_data`=0, `count`=0, `empty`=1, `full`=0, `byp_hit`=0, `byp_data`=0.

## Timing
- The request is accepted at edge N into an empty queue with `drain_en`=1.
- The entry is popped at edge N+1, and `we_onehot`/`wr_data` are valid during cycle N+1.
- The register flop captures the value at edge N+2.
- Minimum acceptance-to-register latency is 2 edges.
- Throughput is one push and one pop per cycle.
- A queue of `DEPTH` entries empties in exactly `DEPTH` cycles of continuous `drain_en`.
- `count`, `empty` and `full` are registered and reflect the state after the last edge.
- `in_ready` is combinational from `full`.
- Bypass outputs are combinational from `rd_addr` and the current state.

## Configuration
- `REGFILE_WB_BYPASS_EN` defined:
  - `byp_hit`/`byp_data` search all valid FIFO entries plus the output stage. The output stage counts as pending while `we_onehot` is nonzero.
  - Priority on a match: the output stage is oldest and the FIFO tail-1 is youngest; the youngest match wins.
  - `rd_addr == 0` never hits.
- Macro not defined:
  - `byp_hit`=0 and `byp_data`=0 constantly.
  - `rd_addr` is ignored and no comparator logic is built.

## Test plan
- Reset then a single push of addr 3, data 0xDEADBEEF with `drain_en`=1: `we_onehot`=0x00000008 and `wr_data`=0xDEADBEEF for exactly one cycle, two edges after the push; `count` returns to 0.
- Hold `drain_en`=0 and push addrs 1, 2, 3, 4 with data 0x11..0x44: `full`=1 and `in_ready`=0 after the 4th push. A 5th push is refused and `count` stays 4. Release `drain_en`: enables 0x2, 0x4, 0x8, 0x10 appear in order on consecutive cycles.
- Push to addr 0 with data 0xFFFFFFFF: `count` stays 0 and `we_onehot` stays 0 throughout.
- With the queue holding 2 entries, simultaneous push and pop: `count` stays 2 and the tail wraps correctly across 3 or more full-depth cycles; the drained order matches push order.
- With `drain_en`=0 and 3 entries held, assert `clr` for one edge with `in_valid`=1: `count`=0, `we_onehot`=0 and `empty`=1. No stale enables appear after `drain_en` returns to 1.
- With `REGFILE_WB_BYPASS_EN` and `drain_en`=0, push (5, 0xA) then (5, 0xB), with `rd_addr`=5: `byp_hit`=1 and `byp_data`=0xB. With `rd_addr`=0: `byp_hit`=0. Without the macro: `byp_hit`=0 in all cases.
